// File: rtl/pcseq_pkg.sv
// pcseq_pkg -- shared types and helpers for the program-counter sequencer.
//   next_sel_e : next-PC source chosen by the priority decode.
//   lvl_width  : bits needed to count 0..depth stack entries.
package pcseq_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_ABS  = 3'd1,
    SEL_REL  = 3'd2,
    SEL_CALL = 3'd3,
    SEL_RET  = 3'd4
  } next_sel_e;

  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// ras_stack -- return-address stack with registered level and status.
// Ports:
//   clk, reset      : clock, synchronous active-low reset
//   push, pop       : push data_in / pop newest entry (pop wins if both)
//   data_in [W]     : address to push
//   top [W]         : newest entry (valid when not empty)
//   level [LW]      : entries held; full / empty registered status
// Build option PCSEQ_RAS_CIRCULAR_EN: a push while full overwrites the
// oldest entry instead of being dropped.
module ras_stack
  import pcseq_pkg::*;
#(
  parameter int W     = 10,
  parameter int DEPTH = 4,
  localparam int LW   = lvl_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  data_in,
  output logic [W-1:0]  top,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] ptr_inc_s;
  logic [PW-1:0] ptr_dec_s;
  logic [PW-1:0] ptr_nxt_s;
  logic [LW-1:0] level_r;
  logic [LW-1:0] level_nxt_s;
  logic          full_r;
  logic          empty_r;
  logic          push_ok_s;
  logic          do_pop_s;

  // Write pointer neighbours; the pointer wraps modulo DEPTH so the same
  // storage serves both the linear and the circular build.
  always_comb begin
    if (wr_ptr_r == PW'(DEPTH - 1)) begin
      ptr_inc_s = '0;
    end else begin
      ptr_inc_s = wr_ptr_r + PW'(1'b1);
    end
    if (wr_ptr_r == '0) begin
      ptr_dec_s = PW'(DEPTH - 1);
    end else begin
      ptr_dec_s = wr_ptr_r - PW'(1'b1);
    end
  end

  // Decide which operation actually takes effect this cycle.
  always_comb begin
    do_pop_s = pop & ~empty_r;
`ifdef PCSEQ_RAS_CIRCULAR_EN
    push_ok_s = push & ~pop;
`else
    push_ok_s = push & ~pop & ~full_r;
`endif
  end

  // Next level and pointer; a circular push while full keeps level at DEPTH.
  always_comb begin
    level_nxt_s = level_r;
    ptr_nxt_s   = wr_ptr_r;
    if (do_pop_s) begin
      level_nxt_s = level_r - LW'(1'b1);
      ptr_nxt_s   = ptr_dec_s;
    end else if (push_ok_s) begin
      ptr_nxt_s = ptr_inc_s;
      if (full_r) begin
        level_nxt_s = level_r;
      end else begin
        level_nxt_s = level_r + LW'(1'b1);
      end
    end else begin
      level_nxt_s = level_r;
      ptr_nxt_s   = wr_ptr_r;
    end
  end

  // Entry storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (reset && push_ok_s) begin
      mem[wr_ptr_r] <= data_in;
    end
  end

  // Level, pointer and status registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      level_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      wr_ptr_r <= ptr_nxt_s;
      level_r  <= level_nxt_s;
      full_r   <= (level_nxt_s == LW'(DEPTH));
      empty_r  <= (level_nxt_s == '0);
    end
  end

  assign top   = mem[ptr_dec_s];
  assign level = level_r;
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program counter, next-PC adders/priority decode and a
// return-address stack for nested subroutine calls.
// Ports:
//   clk, reset        : clock, synchronous active-low reset
//   en                : advance enable (0 = hold everything)
//   s_inc, s_rel      : sequential / relative-jump selects
//   s_call, s_ret     : call (push pc+1, jump absolute) / return (pop)
//   target [PC_W]     : jump target or signed relative offset
//   pc [PC_W]         : current program counter
//   ras_level, ras_full, ras_empty : stack status (registered)
//   ovf, unf          : sticky overflow / underflow, cleared by reset only
// Build option PCSEQ_RAS_CIRCULAR_EN: call while full overwrites the oldest
// return address (ovf still set) instead of dropping the push.
module pc_sequencer
  import pcseq_pkg::*;
#(
  parameter int              PC_W      = 10,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en,
  input  logic                             s_inc,
  input  logic                             s_rel,
  input  logic                             s_call,
  input  logic                             s_ret,
  input  logic [PC_W-1:0]                  target,
  output logic [PC_W-1:0]                  pc,
  output logic [lvl_width(RAS_DEPTH)-1:0]  ras_level,
  output logic                             ras_full,
  output logic                             ras_empty,
  output logic                             ovf,
  output logic                             unf
);

  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_inc_s;
  logic [PC_W-1:0] pc_nxt_s;
  logic [PC_W-1:0] ras_top_s;
  logic            ovf_r;
  logic            unf_r;
  logic            push_s;
  logic            pop_s;
  logic            full_s;
  logic            empty_s;
  next_sel_e       sel_s;

  // Priority decode: return beats call beats jump beats sequential.
  always_comb begin
    if (s_ret) begin
      sel_s = SEL_RET;
    end else if (s_call) begin
      sel_s = SEL_CALL;
    end else if (!s_inc) begin
      if (s_rel) begin
        sel_s = SEL_REL;
      end else begin
        sel_s = SEL_ABS;
      end
    end else begin
      sel_s = SEL_SEQ;
    end
  end

  // Next-PC mux; adders wrap modulo 2^PC_W, the offset is two's complement.
  always_comb begin
    pc_inc_s = pc_r + PC_W'(1'b1);
    case (sel_s)
      SEL_RET:  pc_nxt_s = empty_s ? pc_inc_s : ras_top_s;
      SEL_CALL: pc_nxt_s = target;
      SEL_ABS:  pc_nxt_s = target;
      SEL_REL:  pc_nxt_s = pc_r + target;
      SEL_SEQ:  pc_nxt_s = pc_inc_s;
      default:  pc_nxt_s = pc_inc_s;
    endcase
  end

  // Stack strobes only fire on an enabled cycle.
  always_comb begin
    push_s = en & (sel_s == SEL_CALL);
    pop_s  = en & (sel_s == SEL_RET);
  end

  ras_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .push    (push_s),
    .pop     (pop_s),
    .data_in (pc_inc_s),
    .top     (ras_top_s),
    .level   (ras_level),
    .full    (full_s),
    .empty   (empty_s)
  );

  // PC register and sticky fault flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_r  <= RESET_PC;
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else if (en) begin
      pc_r  <= pc_nxt_s;
      ovf_r <= ovf_r | (push_s & full_s);
      unf_r <= unf_r | (pop_s & empty_s);
    end else begin
      pc_r  <= pc_r;
      ovf_r <= ovf_r;
      unf_r <= unf_r;
    end
  end

  assign pc        = pc_r;
  assign ras_full  = full_s;
  assign ras_empty = empty_s;
  assign ovf       = ovf_r;
  assign unf       = unf_r;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter and sequencing unit for the microcontroller datapath, replacing the fixed 10-bit PC register, the next-PC adders and muxes, and the single-level return register.
- Generalises PC width and adds a return-address stack (RAS) of configurable depth, so subroutine calls can nest.
- Adds a stall input and sticky stack-fault flags.
- Sits between the control unit (select strobes) and program memory (pc output).

Parameters:
- PC_W, 10, width of PC, jump target and stack entries.
- RAS_DEPTH, 4, number of return-address entries (>=1).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset at next rising clk).
- en  in  1  advance enable; 0 = stall, all state held.
- s_inc  in  1  1 = sequential (pc+1); 0 = take jump.
- s_rel  in  1  jump mode when s_inc=0: 1 = relative (pc+target), 0 = absolute (target).
- s_call  in  1  call: push pc+1, jump to absolute target.
- s_ret  in  1  return: pop top of RAS into pc.
- target  in  PC_W  jump/call target or signed relative offset (from instruction field).
- pc  out  PC_W  current program counter.
- ras_level  out  $clog2(RAS_DEPTH+1)  entries currently held.
- ras_full  out  1  ras_level == RAS_DEPTH.
- ras_empty  out  1  ras_level == 0.
- ovf  out  1  sticky: call attempted while full.
- unf  out  1  sticky: return attempted while empty.

Behaviour:
- Reset (reset=0 at edge): pc=RESET_PC, ras_level=0, ovf=0, unf=0. Stack contents are don't-care. Reset overrides en and all strobes, including mid-call/return.
- en=0: pc, stack, level and flags all hold; strobes are ignored.
- Next-PC priority when en=1: s_ret > s_call > s_inc=0 jump > sequential.
- Sequential: pc <= pc+1, modulo 2^PC_W (wraps from all-ones to 0).
- Absolute jump: pc <= target.
- Relative jump: pc <= pc + target, with target as two's complement PC_W bits and the result wrapping modulo 2^PC_W. An offset of 0 is a self-loop.
- Call, not full: stack[level] <= pc+1 (wrapped), level+1, pc <= target (always absolute; s_rel ignored).
- Call, full: pc <= target, push discarded, level unchanged, ovf <= 1.
- Return, not empty: pc <= stack[level-1], level-1.
- Return, empty: pc <= pc+1, unf <= 1.
- s_call and s_ret both set: return only; the call is ignored with no push and no flag.
- Latency: one cycle. pc reflects the decision made at the preceding edge. Status outputs are registered or derived from registered level, with no combinational path from inputs.
- ovf and unf clear only on reset.

Optional Feature:
- Macro PCSEQ_RAS_CIRCULAR_EN.
- Defined: the RAS is a circular buffer. A call while full overwrites the oldest entry, pc <= target, level stays at RAS_DEPTH, and ovf is still set (flag only, data not lost). A return pops the newest entry as normal.
- Not defined: drop-push behaviour as above.
- Return-while-empty behaviour is identical in both builds.

Decomposition:
- Package pcseq_pkg:
  - next-PC select encoding enum (SEL_SEQ, SEL_ABS, SEL_REL, SEL_CALL, SEL_RET);
  - function computing level width from RAS_DEPTH.
- Sub-module ras_stack (params W, DEPTH): push/pop/data_in/top/level/full/empty, plus the circular option. pc_sequencer owns the PC register, the adders and the priority decode.

Test Plan:
- Reset then 5 cycles s_inc=1, en=1 -> pc 0,1,2,3,4,5. Assert reset=0 mid-run -> pc=0 next edge, flags 0.
- PC_W=10, pc=1020, s_inc=0, s_rel=1, target=10'h3FE (-2) -> pc=1018. From pc=1023 sequential -> pc=0.
- Nested calls at pc=5 (target 100), then pc=100 (target 200), then two returns -> pc 100, 200, 101, 6. Levels 1,2,1,0.
- RAS_DEPTH=4, five calls:
  - default build: fifth jumps, level=4, ovf=1, four returns yield the first four return addresses;
  - PCSEQ_RAS_CIRCULAR_EN build: the oldest address is lost, and the returns yield the newest four return addresses.
- Return while empty at pc=7 -> pc=8, unf=1, and unf stays 1 until reset.
- en=0 with s_call=1 for 3 cycles -> pc and level unchanged. Then s_call=1 and s_ret=1 with level=1 -> pops only, level=0, no ovf.
